hs_rr_arbiter: RTL
==================

# hs_rr_arbiter

Round-robin arbiter that shares one valid/ready downstream channel (a handshake slave, directly or through a register slice) among N_REQ independent handshake masters. Each cycle it selects at most one valid requester, completes that upstream handshake and registers the beat into a single output stage. The output follows the valid/ready protocol used by the existing master/slave/beat blocks. One beat per cycle sustained throughput; one cycle latency.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 32, payload width
- ID_W, 2, width of grant_id; equals clog2(N_REQ), and is 1 when N_REQ = 2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  N_REQ  per-requester valid
- ready_out  out  N_REQ  per-requester ready; at most one bit high
- data_in  in  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- valid_out  out  1  downstream valid (registered)
- ready_in  in  1  downstream ready
- data_out  out  DATA_W  downstream payload (registered)
- grant_id  out  ID_W  index of the requester that sourced data_out (registered)
- xfer_cnt  out  N_REQ*16  per-requester accepted-beat counters; present only with HS_ARB_CNT_EN

## Operation
- Output stage states:
  - EMPTY: valid_out=0.
  - FULL: valid_out=1; data_out and grant_id held.
- load = EMPTY || ready_in. It is the only condition under which a new beat may be taken.
- Arbitration is combinational. Search valid_in starting at index ptr, ascending with wrap. The first set bit is the winner w.
- ready_out[w] = load. All other ready_out bits are 0. If there is no valid_in, all ready_out bits are 0.
- Accept = load && valid_in[w]. On accept:
  - data_out <= data_in[w]
  - grant_id <= w
  - state <= FULL
  - ptr <= (w+1) mod N_REQ
- Transitions:
  - FULL && ready_in && no accept -> EMPTY.
  - FULL && ready_in && accept -> FULL, loaded with the new beat (back-to-back).
  - FULL && !ready_in -> hold. valid_out, data_out and grant_id must not change.
- ptr changes only on accept. A requester that drops valid_in before being granted loses nothing and is skipped.
- ready_out is independent of valid_in[i] for non-winners. No requester sees ready without being the winner.

## Timing
- Reset values: valid_out=0, data_out=0, grant_id=0, ptr=0, ready_out=0, xfer_cnt=0, state EMPTY.
- Latency: an upstream handshake in cycle t gives valid_out=1 with that data in cycle t+1.
- Combinational paths:
  - ready_in -> ready_out
  - valid_in -> ready_out
  - There is no path from valid_in to valid_out.
- Fairness: with all N_REQ continuously valid and ready_in=1, the grant order is 0,1,...,N_REQ-1,0,... Each requester waits at most N_REQ-1 beats.
- Simultaneous events: a downstream handshake and an upstream accept in the same cycle are both honoured, with no bubble.
- Reset asserted mid-transfer: on the next edge, valid_out=0 and the held beat is discarded. ready_out is 0 while rst=1.
- The upstream rule (valid held until ready) is assumed of the masters. The block itself never drops valid_out before the handshake.

## Configuration
- HS_ARB_CNT_EN defined:
  - One 16-bit counter per requester, incremented on each accept of that requester.
  - Counters wrap from 0xFFFF to 0 and reset to 0.
  - Exposed on xfer_cnt.
- Not defined: no counters and no xfer_cnt port. Arbitration behaviour is identical in both builds.

## Structure
- Shared package hs_pkg:
  - default DATA_W
  - counter width constant HS_CNT_W=16
  - the output-stage state enum (EMPTY/FULL), reused by future slice blocks
- Sub-module rr_pick: combinational round-robin priority select. Inputs are a request vector and ptr; outputs are a one-hot grant, a binary index and any_req.
- The top level holds the output register, ptr and the optional counters.

## Test plan
- Single requester 2 streams 0xA0..0xA3 back-to-back with ready_in=1 -> valid_out high 4 consecutive cycles; data_out 0xA0..0xA3 one cycle after each accept; grant_id=2 on every beat.
- All 4 requesters valid continuously, ready_in=1 -> grant_id sequence 0,1,2,3,0,1; exactly one ready_out bit high per cycle.
- Beat 0x55 held with ready_in=0 for 5 cycles while requesters 1 and 3 are valid -> data_out stays 0x55; all ready_out=0; after ready_in=1 the next beat is from requester 1.
- ptr=2 and only requester 0 valid -> requester 0 is granted; ptr becomes 1.
- rst pulsed while FULL with 0x77 -> next cycle valid_out=0, data_out=0, grant_id=0; first post-reset grant goes to the lowest valid index.
- With HS_ARB_CNT_EN: 65537 beats from requester 1 -> xfer_cnt[1]=1; other counters 0.

Source files
------------

// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : hs_pkg
//  Description : Shared constants and output-stage state type for the
//                valid/ready handshake block family.
//  Revision    : 1.0
// ============================================================================
package hs_pkg;

    localparam int HS_DATA_W = 32;
    localparam int HS_CNT_W  = 16;

    // Output-stage occupancy shared with the register-slice blocks.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hs_stage_e;

endpackage : hs_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority select. Searches req
//                from index ptr upward with wrap; first set bit wins.
//  Revision    : 1.0
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any_req
);

    int w_pos;

    // Walk from the farthest offset down so the closest requester to ptr
    // is the last assignment and therefore wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        w_pos   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            if (req[w_pos]) begin
                grant        = '0;
                grant[w_pos] = 1'b1;
                idx          = ID_W'(w_pos);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/hs_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hs_rr_arbiter
//  Description : Round-robin arbiter merging N_REQ valid/ready masters into
//                one registered output stage. Optional per-requester beat
//                counters enabled by defining HS_ARB_CNT_EN.
//  Revision    : 1.0
// ============================================================================
module hs_rr_arbiter
    import hs_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = HS_DATA_W,
    parameter int ID_W   = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          valid_in,
    output logic [N_REQ-1:0]          ready_out,
    input  logic [N_REQ*DATA_W-1:0]   data_in,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [DATA_W-1:0]         data_out,
    output logic [ID_W-1:0]           grant_id
`ifdef HS_ARB_CNT_EN
    ,
    output logic [N_REQ*HS_CNT_W-1:0] xfer_cnt
`endif
);

    hs_stage_e         r_state;
    hs_stage_e         w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [DATA_W-1:0] r_data;
    logic [ID_W-1:0]   r_grant;

    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_idx;
    logic              w_any;
    logic              w_load;
    logic              w_accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (valid_in),
        .ptr     (r_ptr),
        .grant   (w_grant),
        .idx     (w_idx),
        .any_req (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // ready_out is gated by rst so no master completes a handshake that the
    // reset is about to discard.
    always_comb begin
        w_load      = (r_state == EMPTY) || ready_in;
        w_accept    = w_load && w_any && !rst;
        ready_out   = (w_load && !rst) ? w_grant : '0;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (w_accept) begin
            w_state_nxt = FULL;
            w_ptr_nxt   = (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
        end else if ((r_state == FULL) && ready_in) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_grant <= '0;
        end else if (w_accept) begin
            r_data  <= data_in[int'(w_idx)*DATA_W +: DATA_W];
            r_grant <= w_idx;
        end
    end

    assign valid_out = (r_state == FULL);
    assign data_out  = r_data;
    assign grant_id  = r_grant;

`ifdef HS_ARB_CNT_EN
    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
            logic [HS_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_accept && (w_idx == ID_W'(i))) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign xfer_cnt[i*HS_CNT_W +: HS_CNT_W] = r_cnt;
        end
    endgenerate
`endif

endmodule : hs_rr_arbiter
`default_nettype wire
